// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and registers the
// fetched word toward decode. Optional back-pressure counter enabled by FETCH_STALL_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] stall_count
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // Handshake: a word moves to decode on a rising edge where out_valid && out_ready.
    // While out_valid && !out_ready the output register is frozen; only redirect or
    // reset may drop out_valid without a transfer.
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        load;

    always_comb begin
        load        = !out_valid_q || out_ready;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (redirect_valid) begin
            // The wrong-path word is dropped; its data fields are left as they were.
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
        end else if (load) begin
            out_instr_d = imem_instr;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC_ALIGNED;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            out_pc_q    <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_q + 32'd4;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Counts edges where decode refused a valid word; a redirect edge is not a stall.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && !redirect_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'h0000_0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'h0000_0000;
`endif

endmodule
